// File: rtl/seq_alu_core.sv
// Multi-cycle registered ALU: valid/ready on both sides, persistent Z/S/C/V status,
// bit-serial shifts/rotates. Define SEQ_ALU_MUL_EN to build the iterative multiply (op 16).
module seq_alu_core #(
    parameter int unsigned WORD_W  = 20,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [4:0]         op_i,
    input  logic               mode_i,
    input  logic [WORD_W-1:0]  a_i,
    input  logic [WORD_W-1:0]  b_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WORD_W-1:0]  result_o,
    output logic               zero_o,
    output logic               sign_o,
    output logic               carry_o,
    output logic               ovf_o,
    output logic               illegal_o,
    output logic               busy_o
);

    localparam int unsigned HALF_W = WORD_W / 2;
    localparam int unsigned MCNT_W = $clog2(WORD_W + 1);
    localparam int unsigned CNT_W  = (SHAMT_W > MCNT_W) ? SHAMT_W : MCNT_W;

    localparam logic [WORD_W-1:0] HALF_MASK = {{HALF_W{1'b0}}, {HALF_W{1'b1}}};
    localparam logic [WORD_W-1:0] FULL_MSB  = {1'b1, {(WORD_W-1){1'b0}}};
    localparam logic [WORD_W-1:0] HALF_MSB  = {{HALF_W{1'b0}}, 1'b1, {(HALF_W-1){1'b0}}};

    localparam logic [4:0] OP_NOT  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_XOR  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADC  = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SBB  = 5'd7;
    localparam logic [4:0] OP_INC  = 5'd8;
    localparam logic [4:0] OP_DEC  = 5'd9;
    localparam logic [4:0] OP_SHL  = 5'd10;
    localparam logic [4:0] OP_SHR  = 5'd11;
    localparam logic [4:0] OP_ROL  = 5'd12;
    localparam logic [4:0] OP_ROR  = 5'd13;
    localparam logic [4:0] OP_CMP  = 5'd14;
    localparam logic [4:0] OP_PASS = 5'd15;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'd16;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
`ifdef SEQ_ALU_MUL_EN
        S_MUL,
`endif
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic              mode_q, mode_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              shc_q, shc_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              sign_q, sign_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;
    logic              illegal_q, illegal_d;
    logic              out_valid_q, out_valid_d;
`ifdef SEQ_ALU_MUL_EN
    logic [2*WORD_W-1:0] prod_q, prod_d;
    logic [2*WORD_W-1:0] mcand_q, mcand_d;
`endif

    logic              accept;
    logic [WORD_W-1:0] in_mask;
    logic [WORD_W-1:0] act_mask;
    logic [WORD_W-1:0] act_msb;

    assign in_ready_o = (state_q == S_IDLE) && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign in_mask    = mode_i ? {WORD_W{1'b1}} : HALF_MASK;
    assign act_mask   = mode_q ? {WORD_W{1'b1}} : HALF_MASK;
    assign act_msb    = mode_q ? FULL_MSB : HALF_MSB;

    // Shared adder/subtractor on the captured operands; carry/borrow taken at the active width.
    logic              do_sub;
    logic              cin;
    logic [WORD_W-1:0] opnd_b;
    logic [WORD_W:0]   arith_w;
    logic [WORD_W-1:0] arith_res;
    logic              arith_c;
    logic              arith_v;
    logic              sa, sb, sr;

    always_comb begin
        opnd_b = b_q;
        cin    = 1'b0;
        do_sub = 1'b0;
        case (op_q)
            OP_ADC:         cin = carry_q;
            OP_SUB, OP_CMP: do_sub = 1'b1;
            OP_SBB: begin
                do_sub = 1'b1;
                cin    = carry_q;
            end
            OP_INC:         opnd_b = WORD_W'(1);
            OP_DEC: begin
                do_sub = 1'b1;
                opnd_b = WORD_W'(1);
            end
            default: ;
        endcase
        if (do_sub) begin
            arith_w = {1'b0, a_q} - {1'b0, opnd_b} - {{WORD_W{1'b0}}, cin};
        end else begin
            arith_w = {1'b0, a_q} + {1'b0, opnd_b} + {{WORD_W{1'b0}}, cin};
        end
        arith_res = arith_w[WORD_W-1:0] & act_mask;
        arith_c   = mode_q ? arith_w[WORD_W] : arith_w[HALF_W];
        sa        = |(a_q & act_msb);
        sb        = |(opnd_b & act_msb);
        sr        = |(arith_res & act_msb);
        arith_v   = do_sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    end

    // Single-cycle op results; exec_fres is the value zero/sign are taken from (a-b for CMP).
    logic [WORD_W-1:0] exec_res;
    logic [WORD_W-1:0] exec_fres;
    logic              exec_c;
    logic              exec_v;
    logic              exec_ill;

    always_comb begin
        exec_res  = '0;
        exec_fres = '0;
        exec_c    = 1'b0;
        exec_v    = 1'b0;
        exec_ill  = 1'b0;
        case (op_q)
            OP_NOT:  exec_res = ~a_q & act_mask;
            OP_AND:  exec_res = a_q & b_q;
            OP_OR:   exec_res = a_q | b_q;
            OP_XOR:  exec_res = a_q ^ b_q;
            OP_PASS: exec_res = b_q;
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC: begin
                exec_res = arith_res;
                exec_c   = arith_c;
                exec_v   = arith_v;
            end
            OP_CMP: begin
                exec_res  = a_q;
                exec_fres = arith_res;
                exec_c    = arith_c;
                exec_v    = arith_v;
            end
            default: exec_ill = 1'b1;
        endcase
        if (op_q != OP_CMP) begin
            exec_fres = exec_res;
        end
    end

    logic              fin;
    logic [WORD_W-1:0] fin_res;
    logic [WORD_W-1:0] fin_fres;
    logic              fin_c;
    logic              fin_v;
    logic              fin_ill;

    // Next-state, datapath stepping and commit of result/status on completion.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mode_d      = mode_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        shc_d       = shc_q;
        result_d    = result_q;
        zero_d      = zero_q;
        sign_d      = sign_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;
`ifdef SEQ_ALU_MUL_EN
        prod_d      = prod_q;
        mcand_d     = mcand_q;
`endif
        fin         = 1'b0;
        fin_res     = '0;
        fin_fres    = '0;
        fin_c       = 1'b0;
        fin_v       = 1'b0;
        fin_ill     = 1'b0;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = op_i;
                    mode_d = mode_i;
                    a_d    = a_i & in_mask;
                    b_d    = b_i & in_mask;
                    cnt_d  = CNT_W'(shamt_i);
                    shc_d  = 1'b0;
                    if ((op_i >= OP_SHL) && (op_i <= OP_ROR)) begin
                        state_d = S_SHIFT;
`ifdef SEQ_ALU_MUL_EN
                    end else if (op_i == OP_MUL) begin
                        state_d = S_MUL;
                        cnt_d   = mode_i ? CNT_W'(WORD_W) : CNT_W'(HALF_W);
                        prod_d  = '0;
                        mcand_d = {{WORD_W{1'b0}}, a_i & in_mask};
`endif
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                fin      = 1'b1;
                fin_res  = exec_res;
                fin_fres = exec_fres;
                fin_c    = exec_c;
                fin_v    = exec_v;
                fin_ill  = exec_ill;
                state_d  = S_DONE;
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    fin      = 1'b1;
                    fin_res  = a_q;
                    fin_fres = a_q;
                    fin_c    = shc_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    case (op_q)
                        OP_SHL: begin
                            shc_d = |(a_q & act_msb);
                            a_d   = (a_q << 1) & act_mask;
                        end
                        OP_SHR: begin
                            shc_d = a_q[0];
                            a_d   = a_q >> 1;
                        end
                        OP_ROL: begin
                            shc_d = |(a_q & act_msb);
                            a_d   = ((a_q << 1) | {{(WORD_W-1){1'b0}}, |(a_q & act_msb)}) & act_mask;
                        end
                        OP_ROR: begin
                            shc_d = a_q[0];
                            a_d   = (a_q >> 1) | (a_q[0] ? act_msb : '0);
                        end
                        default: ;
                    endcase
                end
            end
`ifdef SEQ_ALU_MUL_EN
            S_MUL: begin
                if (cnt_q == '0) begin
                    fin      = 1'b1;
                    fin_res  = prod_q[WORD_W-1:0] & act_mask;
                    fin_fres = fin_res;
                    fin_c    = mode_q ? |prod_q[2*WORD_W-1:WORD_W] : |prod_q[WORD_W-1:HALF_W];
                    state_d  = S_DONE;
                end else begin
                    if (b_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Illegal ops report a zero result and leave the status bits untouched.
        if (fin) begin
            out_valid_d = 1'b1;
            illegal_d   = fin_ill;
            result_d    = fin_ill ? '0 : fin_res;
            if (!fin_ill) begin
                zero_d  = (fin_fres == '0);
                sign_d  = |(fin_fres & act_msb);
                carry_d = fin_c;
                ovf_d   = fin_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            mode_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            shc_q       <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            prod_q      <= '0;
            mcand_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mode_q      <= mode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            shc_q       <= shc_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            sign_q      <= sign_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
`ifdef SEQ_ALU_MUL_EN
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
`endif
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign sign_o      = sign_q;
    assign carry_o     = carry_q;
    assign ovf_o       = ovf_q;
    assign illegal_o   = illegal_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
